// File: rtl/dct_pkg.sv
// Shared types and constants for the 8x8 DCT row/column transpose path.
// Coefficients are opaque signed words; this path never does arithmetic on them.
package dct_pkg;

    localparam int DCT_N     = 8;
    localparam int DCT_WIDTH = 32;
    localparam int DCT_IDX_W = $clog2(DCT_N);

    typedef logic signed [DCT_WIDTH-1:0] dct_coef_t;
    typedef dct_coef_t                   dct_vec_t [DCT_N];
    typedef logic [DCT_IDX_W-1:0]        dct_idx_t;

    localparam dct_idx_t DCT_LAST_IDX = dct_idx_t'(DCT_N - 1);

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } dct_bank_state_e;

    // Row/column pointers wrap from N-1 back to 0.
    function automatic dct_idx_t dct_idx_next(input dct_idx_t idx);
        return (idx == DCT_LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/dct_transpose_buffer_if.sv
// Row-in / column-out handshake bundle between the row-pass and column-pass DCT stages.
// The master drives rows and column acceptance; the slave (the transpose buffer) answers.
interface dct_transpose_buffer_if;
    import dct_pkg::*;

    logic     in_valid;
    logic     in_ready;
    dct_vec_t in_data;
    logic     out_valid;
    logic     out_ready;
    dct_vec_t out_data;
    logic     out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/dct_transpose_bank.sv
// One N x N coefficient store: written a whole row at a time, read a whole column at a time.
// Contents are deliberately not reset; bank occupancy is tracked by the owner.
module dct_transpose_bank
    import dct_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_wr_en,
    input  dct_idx_t i_wr_row,
    input  dct_vec_t i_wr_data,
    input  dct_idx_t i_rd_col,
    output dct_vec_t o_rd_data
);

    dct_coef_t r_mem [DCT_N][DCT_N];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int c = 0; c < DCT_N; c++) begin
                r_mem[i_wr_row][c] <= i_wr_data[c];
            end
        end
    end

    // Column read is a plain mux so column 0 is available the cycle after the bank fills.
    always_comb begin
        for (int r = 0; r < DCT_N; r++) begin
            o_rd_data[r] = r_mem[r][i_rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong transpose buffer: rows from the row-pass DCT fill one bank while the
// other bank is emptied column by column into the column-pass DCT.
module dct_transpose_buffer
    import dct_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    dct_transpose_buffer_if.slave io_bus
);

    // bank state | meaning
    // BANK_EMPTY | free for the writer (possibly partly written)
    // BANK_FULL  | complete block, owned by the reader until its last column leaves

    dct_bank_state_e r_bank_state [2];
    dct_bank_state_e w_bank_state_nxt [2];
    logic            r_wr_bank;
    logic            r_rd_bank;
    logic            w_wr_bank_nxt;
    logic            w_rd_bank_nxt;
    dct_idx_t        r_wr_row;
    dct_idx_t        r_rd_col;
    dct_idx_t        w_wr_row_nxt;
    dct_idx_t        w_rd_col_nxt;

    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_wr_en0;
    logic            w_wr_en1;
    dct_vec_t        w_rd_data0;
    dct_vec_t        w_rd_data1;

    // Handshake outputs are forced low while reset is asserted.
    assign w_in_ready  = !i_rst && (r_bank_state[r_wr_bank] == BANK_EMPTY);
    assign w_out_valid = !i_rst && (r_bank_state[r_rd_bank] == BANK_FULL);
    assign w_in_fire   = io_bus.in_valid && w_in_ready;
    assign w_out_fire  = w_out_valid && io_bus.out_ready;

    assign w_wr_en0 = w_in_fire && (r_wr_bank == 1'b0);
    assign w_wr_en1 = w_in_fire && (r_wr_bank == 1'b1);

    dct_transpose_bank u_bank0 (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en0),
        .i_wr_row  (r_wr_row),
        .i_wr_data (io_bus.in_data),
        .i_rd_col  (r_rd_col),
        .o_rd_data (w_rd_data0)
    );

    dct_transpose_bank u_bank1 (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en1),
        .i_wr_row  (r_wr_row),
        .i_wr_data (io_bus.in_data),
        .i_rd_col  (r_rd_col),
        .o_rd_data (w_rd_data1)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bank_state[0] <= BANK_EMPTY;
            r_bank_state[1] <= BANK_EMPTY;
            r_wr_bank       <= 1'b0;
            r_rd_bank       <= 1'b0;
            r_wr_row        <= '0;
            r_rd_col        <= '0;
        end else begin
            r_bank_state[0] <= w_bank_state_nxt[0];
            r_bank_state[1] <= w_bank_state_nxt[1];
            r_wr_bank       <= w_wr_bank_nxt;
            r_rd_bank       <= w_rd_bank_nxt;
            r_wr_row        <= w_wr_row_nxt;
            r_rd_col        <= w_rd_col_nxt;
        end
    end

    // Writer and reader always own different banks, so both updates can land in one cycle.
    always_comb begin
        w_bank_state_nxt[0] = r_bank_state[0];
        w_bank_state_nxt[1] = r_bank_state[1];
        w_wr_bank_nxt       = r_wr_bank;
        w_rd_bank_nxt       = r_rd_bank;
        w_wr_row_nxt        = r_wr_row;
        w_rd_col_nxt        = r_rd_col;

        if (w_in_fire) begin
            w_wr_row_nxt = dct_idx_next(r_wr_row);
            if (r_wr_row == DCT_LAST_IDX) begin
                w_bank_state_nxt[r_wr_bank] = BANK_FULL;
                w_wr_bank_nxt               = ~r_wr_bank;
            end
        end

        if (w_out_fire) begin
            w_rd_col_nxt = dct_idx_next(r_rd_col);
            if (r_rd_col == DCT_LAST_IDX) begin
                w_bank_state_nxt[r_rd_bank] = BANK_EMPTY;
                w_rd_bank_nxt               = ~r_rd_bank;
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = w_out_valid;
    assign io_bus.out_last  = w_out_valid && (r_rd_col == DCT_LAST_IDX);

    // Data is zeroed when no column is offered so stale bank contents never leak out.
    always_comb begin
        for (int r = 0; r < DCT_N; r++) begin
            if (!w_out_valid) begin
                io_bus.out_data[r] = '0;
            end else if (r_rd_bank) begin
                io_bus.out_data[r] = w_rd_data1[r];
            end else begin
                io_bus.out_data[r] = w_rd_data0[r];
            end
        end
    end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Bench for dct_transpose_buffer: a block-queue reference model checked every cycle,
// plus directed literal checks for latency, backpressure, stalls and mid-block reset.
module tb_dct_transpose_buffer;
    import dct_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dct_transpose_buffer_if bus ();

    dct_transpose_buffer dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: complete blocks queued row-major; the head block is being read.
    logic [31:0] m_coef [$];
    logic [31:0] m_part [64];
    int          m_rows = 0;
    int          m_col  = 0;
    int          m_cyc  = 0;
    int          m_rows_acc = 0;
    int          m_cols_out = 0;
    int          m_last_row_cyc = -1;
    int          m_first_in = -1, m_last_in = -1, m_first_out = -1, m_last_out = -1;
    bit          m_in_fire = 1'b0;
    bit          chk_en = 1'b0;
    int          mon_inready_low = 0;

    function automatic int m_full();
        return m_coef.size() / 64;
    endfunction

    always @(posedge clk) begin
        bit inf, outf;
        m_cyc++;
        if (rst) begin
            m_coef.delete();
            m_rows    = 0;
            m_col     = 0;
            m_in_fire = 1'b0;
        end else begin
            inf  = bus.in_valid && (m_full() < 2);
            outf = (m_full() > 0) && bus.out_ready;
            m_in_fire = inf;
            if (outf) begin
                m_cols_out++;
                if (m_first_out < 0) m_first_out = m_cyc;
                m_last_out = m_cyc;
                if (m_col == 7) begin
                    repeat (64) void'(m_coef.pop_front());
                    m_col = 0;
                end else begin
                    m_col++;
                end
            end
            if (inf) begin
                for (int c = 0; c < 8; c++) m_part[m_rows*8 + c] = bus.in_data[c];
                m_rows_acc++;
                if (m_first_in < 0) m_first_in = m_cyc;
                m_last_in = m_cyc;
                if (m_rows == 7) begin
                    for (int i = 0; i < 64; i++) m_coef.push_back(m_part[i]);
                    m_rows = 0;
                    m_last_row_cyc = m_cyc;
                end else begin
                    m_rows++;
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = !rst && (m_full() > 0);
            check_bit("in_ready", bus.in_ready, !rst && (m_full() < 2));
            check_bit("out_valid", bus.out_valid, ev);
            check_bit("out_last", bus.out_last, ev && (m_col == 7));
            if (ev) begin
                for (int r = 0; r < 8; r++)
                    check_word("out_data", bus.out_data[r], m_coef[r*8 + m_col]);
            end
            if (rst) begin
                for (int r = 0; r < 8; r++)
                    check_word("out_data_in_reset", bus.out_data[r], 32'h0);
            end
            if (!rst && !bus.in_ready) mon_inready_low++;
        end
    end

    // Upstream/downstream driver; rows are held until the model sees them accepted.
    logic [31:0] src [$];
    int          src_idx = 0;

    task automatic cyc(input int vpct, input int rpct, input logic rst_val);
        bit have;
        @(posedge clk);
        #2;
        if (m_in_fire) src_idx++;
        have = (src_idx*8 < src.size());
        rst = rst_val;
        bus.in_valid = !rst_val && have && ($urandom_range(99) < vpct);
        for (int c = 0; c < 8; c++) bus.in_data[c] = have ? src[src_idx*8 + c] : 32'h0;
        bus.out_ready = ($urandom_range(99) < rpct);
    endtask

    function automatic bit drained();
        return (src_idx*8 >= src.size()) && (m_coef.size() == 0) && (m_rows == 0);
    endfunction

    task automatic drain(input int vpct, input int rpct, input int budget);
        int n = 0;
        while (!drained() && n < budget) begin
            cyc(vpct, rpct, 1'b0);
            n++;
        end
        check_bit("drain_within_budget", drained(), 1'b1);
    endtask

    task automatic push_block(input logic [31:0] base);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) src.push_back(base + 32'(16*r + c));
    endtask

    function automatic logic [31:0] rnd_coef();
        case ($urandom_range(9))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One block X[r][c] = base + 16r + c with literal column expectations.
    task automatic run_literal_block(input logic [31:0] base);
        int col = 0;
        int first = -1;
        push_block(base);
        for (int k = 0; k < 24; k++) begin
            cyc(100, 100, 1'b0);
            @(negedge clk);
            if (bus.out_valid) begin
                if (first < 0) first = m_cyc;
                for (int r = 0; r < 8; r++)
                    check_word("lit_col_data", bus.out_data[r], base + 32'(16*r + col));
                check_bit("lit_col_last", bus.out_last, col == 7);
                col++;
            end
        end
        check_word("lit_col_count", 32'(col), 32'd8);
        // First valid column is seen in the cycle right after row 7's transfer edge.
        check_word("lit_latency", 32'(first), 32'(m_last_row_cyc));
    endtask

    task automatic check_idle_after_reset(input string tag);
        check_bit({tag, "_in_ready"}, bus.in_ready, 1'b1);
        check_bit({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check_bit({tag, "_out_last"}, bus.out_last, 1'b0);
        for (int r = 0; r < 8; r++) check_word({tag, "_out_data"}, bus.out_data[r], 32'h0);
    endtask

    initial begin
        int rows0, cols0, got_last, n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 8; c++) bus.in_data[c] = 32'h0;

        // Reset state
        cyc(0, 0, 1'b1);
        chk_en = 1'b1;
        cyc(0, 0, 1'b1);
        @(negedge clk);
        check_bit("rst_in_ready", bus.in_ready, 1'b0);
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check_bit("rst_out_last", bus.out_last, 1'b0);
        cyc(0, 0, 1'b0);
        @(negedge clk);
        check_idle_after_reset("post_rst");

        // 1: single block, X[r][c] = 16r + c
        run_literal_block(32'h0);

        // 2: four blocks back to back, no bubbles
        push_block(32'h0000_0100);
        push_block(32'h0000_0200);
        push_block(32'h0000_0300);
        push_block(32'h0000_0400);
        mon_inready_low = 0;
        m_first_in = -1; m_first_out = -1;
        cols0 = m_cols_out;
        drain(100, 100, 200);
        check_word("t2_inready_low_cycles", 32'(mon_inready_low), 32'd0);
        check_word("t2_cols", 32'(m_cols_out - cols0), 32'd32);
        check_word("t2_in_span", 32'(m_last_in - m_first_in + 1), 32'd32);
        check_word("t2_out_span", 32'(m_last_out - m_first_out + 1), 32'd32);

        // 3: consumer blocked, three blocks offered
        push_block(32'h0000_1000);
        push_block(32'h0000_1100);
        push_block(32'h0000_1200);
        rows0 = m_rows_acc;
        for (int k = 0; k < 30; k++) cyc(100, 0, 1'b0);
        @(negedge clk);
        check_word("t3_rows_accepted", 32'(m_rows_acc - rows0), 32'd16);
        check_bit("t3_in_ready_full", bus.in_ready, 1'b0);
        check_bit("t3_out_valid", bus.out_valid, 1'b1);
        check_bit("t3_out_last", bus.out_last, 1'b0);
        for (int r = 0; r < 8; r++)
            check_word("t3_held_col0", bus.out_data[r], 32'h0000_1000 + 32'(16*r));
        got_last = 0;
        n = 0;
        while (!drained() && n < 300) begin
            cyc(100, 100, 1'b0);
            @(negedge clk);
            if (got_last == 1) begin
                check_bit("t3_in_ready_after_last", bus.in_ready, 1'b1);
                got_last = 2;
            end
            if (got_last == 0 && bus.out_last && bus.out_ready) begin
                check_bit("t3_in_ready_at_last", bus.in_ready, 1'b0);
                got_last = 1;
            end
            n++;
        end
        check_word("t3_release_seen", 32'(got_last), 32'd2);
        check_bit("t3_drained", drained(), 1'b1);

        // 4: random handshakes, 100 random blocks including extreme values
        for (int i = 0; i < 100 * 64; i++) src.push_back(rnd_coef());
        cols0 = m_cols_out;
        drain(60, 60, 20000);
        check_word("t4_cols", 32'(m_cols_out - cols0), 32'd800);

        // 5: reset with 5 rows in one bank and column 3 pending in the other
        push_block(32'h0000_2000);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 8; c++) src.push_back(32'h0000_2800 + 32'(16*r + c));
        rows0 = m_rows_acc;
        for (int k = 0; k < 15; k++) cyc(100, 0, 1'b0);
        check_word("t5_rows_accepted", 32'(m_rows_acc - rows0), 32'd13);
        for (int k = 0; k < 3; k++) cyc(0, 100, 1'b0);
        cyc(0, 0, 1'b0);
        @(negedge clk);
        check_word("t5_model_col", 32'(m_col), 32'd3);
        for (int r = 0; r < 8; r++)
            check_word("t5_col3", bus.out_data[r], 32'h0000_2000 + 32'(16*r + 3));
        cyc(0, 0, 1'b1);
        @(negedge clk);
        check_bit("t5_rst_out_valid", bus.out_valid, 1'b0);
        check_bit("t5_rst_in_ready", bus.in_ready, 1'b0);
        cyc(0, 0, 1'b0);
        @(negedge clk);
        check_idle_after_reset("t5_post_rst");
        run_literal_block(32'h0000_3000);

        // 6: stall in the middle of a block and on its last column
        push_block(32'h0000_6000);
        for (int k = 0; k < 10; k++) cyc(100, 0, 1'b0);
        cyc(0, 100, 1'b0);
        cyc(0, 100, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 1'b0);
            @(negedge clk);
            check_bit("t6_valid", bus.out_valid, 1'b1);
            check_bit("t6_last", bus.out_last, 1'b0);
            for (int r = 0; r < 8; r++)
                check_word("t6_col2", bus.out_data[r], 32'h0000_6000 + 32'(16*r + 2));
        end
        for (int k = 0; k < 5; k++) cyc(0, 100, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1'b0);
            @(negedge clk);
            check_bit("t6_last_held", bus.out_last, 1'b1);
            for (int r = 0; r < 8; r++)
                check_word("t6_col7", bus.out_data[r], 32'h0000_6000 + 32'(16*r + 7));
        end
        drain(100, 100, 50);

        cyc(0, 0, 1'b0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
